// File: rtl/simon_core_param.sv
// Simon Says game controller: LFSR-filled colour sequence, timed replay on
// one-hot lamps, and per-press checking with timeout and multi-press rejection.
module simon_core_param #(
  parameter int COLOUR_W       = 2,
  parameter int MAX_LEN        = 16,
  parameter int LEN_W          = 5,
  parameter int HOLD_CYCLES    = 10,
  parameter int GAP_CYCLES     = 5,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               seed,
  input  logic [2**COLOUR_W-1:0]   btn,
  output logic [2**COLOUR_W-1:0]   colour_out,
  output logic                     colour_oe,
  output logic [2:0]               state,
  output logic [LEN_W-1:0]         round,
  output logic [LEN_W-1:0]         score,
  output logic                     win,
  output logic                     lose,
  output logic                     busy
);

  localparam int N     = 2**COLOUR_W;
  localparam int IW    = $clog2(MAX_LEN);
  localparam int TMAX0 = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TMAX  = (TMAX0 > TIMEOUT_CYCLES) ? TMAX0 : TIMEOUT_CYCLES;
  localparam int TW    = $clog2(TMAX + 1);

  localparam logic [TW-1:0] H_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] G_LAST = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILL     = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_GAP = 3'd3,
    S_WAIT_IN  = 3'd4,
    S_ROUND_OK = 3'd5,
    S_WIN      = 3'd6,
    S_LOSE     = 3'd7
  } state_t;

  state_t                st;
  logic [7:0]            lfsr;
  logic [COLOUR_W-1:0]   mem [MAX_LEN];
  logic [LEN_W-1:0]      idx;
  logic [LEN_W-1:0]      nxt_idx;
  logic [TW-1:0]         timer;
  logic [N-1:0]          btn_q;
  logic [N-1:0]          btn_prev;
  logic [N-1:0]          want;
  logic [N-1:0]          want_next;
  logic [N-1:0]          first;
  logic                  press;
  logic                  multi;

  assign state     = st;
  assign nxt_idx   = idx + LEN_W'(1);
  assign want      = N'(1) << mem[idx[IW-1:0]];
  assign want_next = N'(1) << mem[nxt_idx[IW-1:0]];
  assign first     = N'(1) << mem[0];
  // A press only counts as a rising edge out of the all-released state.
  assign press     = (btn_q != '0) && (btn_prev == '0);
  assign multi     = (btn_q & (btn_q - N'(1))) != '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= S_IDLE;
      lfsr       <= '0;
      idx        <= '0;
      timer      <= '0;
      btn_q      <= '0;
      btn_prev   <= '0;
      colour_out <= '0;
      colour_oe  <= 1'b0;
      round      <= '0;
      score      <= '0;
      win        <= 1'b0;
      lose       <= 1'b0;
      busy       <= 1'b0;
      for (int unsigned i = 0; i < MAX_LEN; i++) mem[IW'(i)] <= '0;
    end else begin
      btn_q    <= btn;
      btn_prev <= btn_q;
      case (st)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start) begin
            // Only a fresh game reseeds; replays continue the LFSR stream.
            if (st == S_IDLE) lfsr <= (seed == '0) ? 8'h01 : seed;
            idx   <= '0;
            timer <= '0;
            score <= '0;
            win   <= 1'b0;
            lose  <= 1'b0;
            busy  <= 1'b1;
            st    <= S_FILL;
          end
        end
        S_FILL: begin
          mem[idx[IW-1:0]] <= lfsr[COLOUR_W-1:0];
          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
          if (idx == LEN_W'(MAX_LEN - 1)) begin
            idx        <= '0;
            timer      <= '0;
            round      <= LEN_W'(1);
            colour_out <= first;
            colour_oe  <= 1'b1;
            st         <= S_SHOW_ON;
          end else begin
            idx <= nxt_idx;
          end
        end
        S_SHOW_ON: begin
          if (timer == H_LAST) begin
            timer      <= '0;
            colour_out <= '0;
            colour_oe  <= 1'b0;
            st         <= S_SHOW_GAP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_SHOW_GAP: begin
          if (timer == G_LAST) begin
            timer <= '0;
            if (nxt_idx == round) begin
              idx <= '0;
              st  <= S_WAIT_IN;
            end else begin
              idx        <= nxt_idx;
              colour_out <= want_next;
              colour_oe  <= 1'b1;
              st         <= S_SHOW_ON;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_WAIT_IN: begin
          if (press) begin
            if (!multi && (btn_q == want)) begin
              timer <= '0;
              if (idx == round - LEN_W'(1)) st <= S_ROUND_OK;
              else                          idx <= nxt_idx;
            end else begin
              lose <= 1'b1;
              busy <= 1'b0;
              st   <= S_LOSE;
            end
          end else if (TIMEOUT_CYCLES != 0) begin
            if (timer == T_LAST) begin
              lose <= 1'b1;
              busy <= 1'b0;
              st   <= S_LOSE;
            end else begin
              timer <= timer + TW'(1);
            end
          end
        end
        S_ROUND_OK: begin
          score <= round;
          if (round == LEN_W'(MAX_LEN)) begin
            win  <= 1'b1;
            busy <= 1'b0;
            st   <= S_WIN;
          end else begin
            round      <= round + LEN_W'(1);
            idx        <= '0;
            timer      <= '0;
            colour_out <= first;
            colour_oe  <= 1'b1;
            st         <= S_SHOW_ON;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_core_param.sv
// Bench for simon_core_param: two instances (16-long game with 50-cycle timeout,
// 2-long game with timeout disabled) checked every cycle against a scripted game model.
module tb_simon_core_param;

  localparam int HOLD = 10;
  localparam int GAP  = 5;
  localparam int MAXL [2] = '{16, 2};

  logic       clk = 1'b0;
  logic       rst   [2];
  logic       start [2];
  logic [7:0] seed  [2];
  logic [3:0] btn   [2];

  logic [3:0] col_o  [2];
  logic       oe_o   [2];
  logic [2:0] st_o   [2];
  logic [4:0] rnd_o  [2];
  logic [4:0] scr_o  [2];
  logic       win_o  [2];
  logic       lose_o [2];
  logic       busy_o [2];

  simon_core_param #(
    .COLOUR_W(2), .MAX_LEN(16), .LEN_W(5),
    .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(50)
  ) u_a (
    .clk(clk), .rst(rst[0]), .start(start[0]), .seed(seed[0]), .btn(btn[0]),
    .colour_out(col_o[0]), .colour_oe(oe_o[0]), .state(st_o[0]), .round(rnd_o[0]),
    .score(scr_o[0]), .win(win_o[0]), .lose(lose_o[0]), .busy(busy_o[0])
  );

  simon_core_param #(
    .COLOUR_W(2), .MAX_LEN(2), .LEN_W(5),
    .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(0)
  ) u_b (
    .clk(clk), .rst(rst[1]), .start(start[1]), .seed(seed[1]), .btn(btn[1]),
    .colour_out(col_o[1]), .colour_oe(oe_o[1]), .state(st_o[1]), .round(rnd_o[1]),
    .score(scr_o[1]), .win(win_o[1]), .lose(lose_o[1]), .busy(busy_o[1])
  );

  always #5 clk = ~clk;

  // Game model: what each instance must be showing in the current cycle.
  int         m_state [2];
  logic [3:0] m_col   [2];
  logic       m_oe    [2];
  int         m_round [2];
  int         m_score [2];
  logic       m_win   [2];
  logic       m_lose  [2];
  int         m_idx   [2];
  logic [7:0] m_lfsr  [2];
  logic [1:0] m_mem   [2][32];

  int   checks   = 0;
  int   failures = 0;
  logic chk_en   = 1'b0;

  task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h want=%0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [3:0] lamp(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  function automatic logic exp_busy(input int s);
    return !(s == 0 || s == 6 || s == 7);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check("state",  i, 32'(st_o[i]),   32'(m_state[i]));
        check("colour", i, 32'(col_o[i]),  32'(m_col[i]));
        check("oe",     i, 32'(oe_o[i]),   32'(m_oe[i]));
        check("round",  i, 32'(rnd_o[i]),  32'(m_round[i]));
        check("score",  i, 32'(scr_o[i]),  32'(m_score[i]));
        check("win",    i, 32'(win_o[i]),  32'(m_win[i]));
        check("lose",   i, 32'(lose_o[i]), 32'(m_lose[i]));
        check("busy",   i, 32'(busy_o[i]), 32'(exp_busy(m_state[i])));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input int i, input int s, input logic [3:0] c, input logic oe);
    m_state[i] = s;
    m_col[i]   = c;
    m_oe[i]    = oe;
  endtask

  task automatic mreset(input int i);
    set_exp(i, 0, 4'b0, 1'b0);
    m_round[i] = 0;
    m_score[i] = 0;
    m_win[i]   = 1'b0;
    m_lose[i]  = 1'b0;
    m_idx[i]   = 0;
    m_lfsr[i]  = 8'h00;
  endtask

  // Start pulse, then MAX_LEN fill cycles; returns in the first lit cycle.
  task automatic do_start(input int i, input logic [7:0] s);
    if (m_state[i] == 0) m_lfsr[i] = (s == 8'h00) ? 8'h01 : s;
    seed[i]  = s;
    start[i] = 1'b1;
    tick();
    start[i]   = 1'b0;
    m_score[i] = 0;
    m_win[i]   = 1'b0;
    m_lose[i]  = 1'b0;
    for (int k = 0; k < MAXL[i]; k++) begin
      set_exp(i, 1, 4'b0, 1'b0);
      m_mem[i][k] = m_lfsr[i][1:0];
      m_lfsr[i]   = lfsr_step(m_lfsr[i]);
      tick();
    end
    m_round[i] = 1;
    set_exp(i, 2, lamp(m_mem[i][0]), 1'b1);
  endtask

  task automatic show(input int i);
    for (int j = 0; j < m_round[i]; j++) begin
      for (int h = 0; h < HOLD; h++) begin set_exp(i, 2, lamp(m_mem[i][j]), 1'b1); tick(); end
      for (int g = 0; g < GAP; g++)  begin set_exp(i, 3, 4'b0, 1'b0); tick(); end
    end
    set_exp(i, 4, 4'b0, 1'b0);
    m_idx[i] = 0;
  endtask

  // Button seen after one edge, judged on the next; a correct non-final press
  // is followed by one released cycle so the next press is a fresh edge.
  task automatic press(input int i, input logic [3:0] b);
    btn[i] = b;
    tick();
    tick();
    btn[i] = 4'b0;
    if ($onehot(b) && b == lamp(m_mem[i][m_idx[i]])) begin
      if (m_idx[i] == m_round[i] - 1) set_exp(i, 5, 4'b0, 1'b0);
      else begin m_idx[i]++; tick(); end
    end else begin
      set_exp(i, 7, 4'b0, 1'b0);
      m_lose[i] = 1'b1;
    end
  endtask

  task automatic round_ok(input int i);
    tick();
    m_score[i] = m_round[i];
    if (m_round[i] == MAXL[i]) begin
      set_exp(i, 6, 4'b0, 1'b0);
      m_win[i] = 1'b1;
    end else begin
      m_round[i]++;
      show(i);
    end
  endtask

  task automatic play_round(input int i);
    for (int j = 0; j < m_round[i]; j++) press(i, lamp(m_mem[i][j]));
    round_ok(i);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; seed[i] = 8'h00; btn[i] = 4'b0;
      mreset(i);
    end
    tick();
    tick();
    chk_en = 1'b1;

    // Instance A: idle hold, then seed 01 game.
    rst[0] = 1'b0;
    repeat (100) tick();
    check("idle_hold", 0, 32'(st_o[0]), 32'd0);

    do_start(0, 8'h01);
    check("seq0", 0, 32'(m_mem[0][0]), 32'd1);
    check("seq1", 0, 32'(m_mem[0][1]), 32'd2);
    check("seq2", 0, 32'(m_mem[0][2]), 32'd0);
    check("seq3", 0, 32'(m_mem[0][3]), 32'd0);
    check("seq4", 0, 32'(m_mem[0][4]), 32'd1);
    check("first_lamp", 0, 32'(col_o[0]), 32'h2);
    check("first_oe",   0, 32'(oe_o[0]),  32'd1);
    show(0);
    check("wait_r1", 0, 32'(rnd_o[0]), 32'd1);
    play_round(0);
    check("wait_r2_score", 0, 32'(scr_o[0]), 32'd1);
    check("wait_r2_round", 0, 32'(rnd_o[0]), 32'd2);
    press(0, 4'b1000);
    check("wrong_lose",  0, 32'(lose_o[0]), 32'd1);
    check("wrong_score", 0, 32'(scr_o[0]),  32'd1);

    // Restart from LOSE continues the LFSR (state 0x4B -> colour 3).
    do_start(0, 8'h01);
    check("noreseed_seq0",  0, 32'(m_mem[0][0]), 32'd3);
    check("noreseed_lamp",  0, 32'(col_o[0]),    32'h8);
    show(0);
    repeat (49) tick();
    check("timeout_early", 0, 32'(st_o[0]), 32'd4);
    tick();
    set_exp(0, 7, 4'b0, 1'b0);
    m_lose[0] = 1'b1;
    check("timeout_lose", 0, 32'(lose_o[0]), 32'd1);

    do_start(0, 8'h00);
    show(0);
    press(0, 4'b0011);
    check("multi_lose", 0, 32'(st_o[0]), 32'd7);

    do_start(0, 8'h00);
    repeat (3) tick();
    rst[0] = 1'b1;
    tick();
    mreset(0);
    rst[0] = 1'b0;
    check("rst_show_state",  0, 32'(st_o[0]),  32'd0);
    check("rst_show_colour", 0, 32'(col_o[0]), 32'd0);
    tick();

    // Instance B: seed 0 maps to 01, no timeout, two rounds to a win.
    rst[1] = 1'b0;
    tick();
    do_start(1, 8'h00);
    check("seed0_seq0", 1, 32'(m_mem[1][0]), 32'd1);
    check("seed0_seq1", 1, 32'(m_mem[1][1]), 32'd2);
    check("seed0_lamp", 1, 32'(col_o[1]),    32'h2);
    show(1);
    repeat (5000) tick();
    check("no_timeout", 1, 32'(st_o[1]), 32'd4);
    play_round(1);
    play_round(1);
    check("win_state", 1, 32'(st_o[1]),  32'd6);
    check("win_flag",  1, 32'(win_o[1]), 32'd1);
    check("win_score", 1, 32'(scr_o[1]), 32'd2);
    repeat (3) tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
